uart_massiv_tx_arbiter: RTL

- Two-requester arbiter and sequencer in front of one UART_TX_RX_MASSIV_MODULE transmit side.
- Each requester presents a data array and a pack count. The block grants the transmitter round-robin, latches the granted array, issues the launch pulse, waits for the done strobe, then reports completion or error to the granted requester.
- Sits between application logic and the TX_MASSIV port group.

---
 rtl/uart_massiv_tx_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_massiv_tx_arbiter.sv
// Round-robin arbiter and launch sequencer for two requesters sharing one
// UART_TX_RX_MASSIV transmit port group.
//
// state     | meaning
// IDLE      | no grant held; arbitrate on request levels
// LOAD      | grant held, array latched; wait for the transmitter to go idle
// LAUNCH    | one-cycle launch pulse, timeout counter cleared
// WAIT_DONE | waiting for the done strobe or the timeout
// FINISH    | one-cycle done/error pulse to the owner, grant released
module uart_massiv_tx_arbiter #(
  parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
  parameter int TX_MASSIV_DEEP           = 2,
  parameter int TX_MASSIV_DEEP_LOG_2     = $clog2(TX_MASSIV_DEEP),
  parameter int DONE_TIMEOUT_CYCLES      = 65535
) (
  input  logic                                                IN_CLOCK,
  input  logic                                                IN_RESET,
  input  logic                                                IN_REQ_A,
  input  logic [NUM_OF_DATA_BITS_IN_PACK*TX_MASSIV_DEEP-1:0]  IN_DATA_A,
  input  logic [TX_MASSIV_DEEP_LOG_2:0]                       IN_NUM_A,
  output logic                                                OUT_BUSY_A,
  output logic                                                OUT_DONE_A,
  output logic                                                OUT_ERR_A,
  input  logic                                                IN_REQ_B,
  input  logic [NUM_OF_DATA_BITS_IN_PACK*TX_MASSIV_DEEP-1:0]  IN_DATA_B,
  input  logic [TX_MASSIV_DEEP_LOG_2:0]                       IN_NUM_B,
  output logic                                                OUT_BUSY_B,
  output logic                                                OUT_DONE_B,
  output logic                                                OUT_ERR_B,
  output logic [NUM_OF_DATA_BITS_IN_PACK*TX_MASSIV_DEEP-1:0]  OUT_TX_DATA_MASSIV,
  output logic [TX_MASSIV_DEEP_LOG_2:0]                       OUT_TX_NUMBER_OF_PACKS_TO_SEND,
  output logic                                                OUT_TX_LAUNCH,
  input  logic                                                IN_TX_ACTIVE,
  input  logic                                                IN_TX_DONE,
  output logic                                                OUT_LAST_GRANT
);

  localparam int DW = NUM_OF_DATA_BITS_IN_PACK * TX_MASSIV_DEEP;
  localparam int NW = TX_MASSIV_DEEP_LOG_2 + 1;
  localparam int CW = $clog2(DONE_TIMEOUT_CYCLES + 1);
  localparam logic [NW-1:0] MAX_NUM  = NW'(TX_MASSIV_DEEP);
  localparam logic [CW-1:0] TMO_LAST = CW'(DONE_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, WAIT_DONE, FINISH} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [NW-1:0]   num_q, num_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic            err_q, err_d;
  logic            grant_a, grant_b;
  logic [NW-1:0]   num_sel;

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      state_q      <= IDLE;
      data_q       <= '0;
      num_q        <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      num_q        <= num_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    num_d        = num_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    err_d        = err_q;
    // On a tie, B wins only when A was the previous winner.
    grant_b      = IN_REQ_B & (~IN_REQ_A | ~last_grant_q);
    grant_a      = IN_REQ_A & ~grant_b;
    num_sel      = grant_b ? IN_NUM_B : IN_NUM_A;
    case (state_q)
      IDLE: begin
        if (grant_a | grant_b) begin
          owner_d      = grant_b;
          last_grant_d = grant_b;
          data_d       = grant_b ? IN_DATA_B : IN_DATA_A;
          num_d        = num_sel;
          if ((num_sel == '0) || (num_sel > MAX_NUM)) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            err_d   = 1'b0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (!IN_TX_ACTIVE) state_d = LAUNCH;
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + CW'(1);
        if (IN_TX_DONE) begin
          err_d   = 1'b0;
          state_d = FINISH;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic busy;
  logic fin;
  assign busy = (state_q != IDLE);
  assign fin  = (state_q == FINISH);

  assign OUT_BUSY_A                     = busy & ~owner_q;
  assign OUT_BUSY_B                     = busy & owner_q;
  assign OUT_DONE_A                     = fin & ~err_q & ~owner_q;
  assign OUT_ERR_A                      = fin & err_q & ~owner_q;
  assign OUT_DONE_B                     = fin & ~err_q & owner_q;
  assign OUT_ERR_B                      = fin & err_q & owner_q;
  assign OUT_TX_LAUNCH                  = (state_q == LAUNCH);
  assign OUT_TX_DATA_MASSIV             = data_q;
  assign OUT_TX_NUMBER_OF_PACKS_TO_SEND = num_q;
  assign OUT_LAST_GRANT                 = last_grant_q;

endmodule
